// File: rtl/bcd_count_pkg.sv
// Shared encodings for the BCD count controller: command opcodes, FSM states
// and the largest legal BCD digit value.
package bcd_count_pkg;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_START = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_LOAD  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LOAD = 2'b10
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade counter stage with clear, sanitising load and ripple enable.
// Priority: clear over load over increment.
module bcd_digit
    import bcd_count_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       ld_i,
    input  logic [3:0] ld_val_i,
    output logic [3:0] q_o,
    output logic       at9_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 4'd0;
        end else if (ld_i) begin
            // Non-BCD nibbles are forced to zero so the count stays legal.
            q_d = (ld_val_i > BCD_MAX) ? 4'd0 : ld_val_i;
        end else if (en_i) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    assign at9_o = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Command-driven sequencer for a cascade of BCD digits: handshake, FSM,
// prescaler, ripple enables and terminal-count (wrap or saturate) handling.
module bcd_count_ctrl
    import bcd_count_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1,
    parameter bit WRAP       = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [4*NUM_DIGITS-1:0] cmd_data_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    running_o,
    output logic                    tc_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_e                  state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic                    tc_q, tc_d;
    logic [4*NUM_DIGITS-1:0] load_data_q, load_data_d;

    cmd_op_e                 op;
    logic                    accept;
    logic                    tick;
    logic                    clr;
    logic                    inc;
    logic                    ld;
    logic [NUM_DIGITS-1:0]   at9;
    logic [NUM_DIGITS:0]     lower9;
    logic                    all9;

    assign op          = cmd_op_e'(cmd_op_i);
    assign cmd_ready_o = (state_q != LOAD);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign tick        = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign ld          = (state_q == LOAD);

    always_comb begin
        lower9[0] = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lower9[i+1] = lower9[i] & at9[i];
        end
    end
    assign all9 = lower9[NUM_DIGITS];

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        tc_d        = 1'b0;
        clr         = 1'b0;
        inc         = 1'b0;
        load_data_d = load_data_q;
        if (accept && op == CMD_LOAD) begin
            load_data_d = cmd_data_i;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        CMD_START: begin
                            state_d = RUN;
                            presc_d = '0;
                        end
                        CMD_LOAD:  state_d = LOAD;
                        CMD_CLEAR: clr = 1'b1;
                        default:   ;
                    endcase
                end
            end
            RUN: begin
                // Any command other than START pre-empts a coincident tick.
                if (accept && op != CMD_START) begin
                    presc_d = '0;
                    case (op)
                        CMD_STOP:  state_d = IDLE;
                        CMD_CLEAR: clr = 1'b1;
                        CMD_LOAD:  state_d = LOAD;
                        default:   ;
                    endcase
                end else if (tick) begin
                    presc_d = '0;
                    if (all9) begin
                        tc_d = 1'b1;
                        if (WRAP) begin
                            inc = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        inc = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            tc_q        <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tc_q        <= tc_d;
            load_data_q <= load_data_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .en_i     (inc & lower9[gi]),
                .clr_i    (clr),
                .ld_i     (ld),
                .ld_val_i (load_data_q[4*gi +: 4]),
                .q_o      (count_o[4*gi +: 4]),
                .at9_o    (at9[gi])
            );
        end
    endgenerate

    assign running_o = (state_q == RUN);
    assign tc_o      = tc_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench: three instances (wrap, saturate, prescale-3) share stimulus;
// each scenario resets first and checks only the instance it targets.
module tb_bcd_count_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;

    logic [7:0] count_a, count_b, count_c;
    logic       ready_a, ready_b, ready_c;
    logic       run_a, run_b, run_c;
    logic       tc_a, tc_b, tc_c;

    int checks = 0;
    int fails  = 0;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    bcd_count_ctrl #(.NUM_DIGITS(2), .PRESCALE(1), .WRAP(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_a),
        .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .count_o(count_a),
        .running_o(run_a), .tc_o(tc_a));

    bcd_count_ctrl #(.NUM_DIGITS(2), .PRESCALE(1), .WRAP(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_b),
        .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .count_o(count_b),
        .running_o(run_b), .tc_o(tc_b));

    bcd_count_ctrl #(.NUM_DIGITS(2), .PRESCALE(3), .WRAP(1'b1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_c),
        .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .count_o(count_c),
        .running_o(run_c), .tc_o(tc_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        issue(OP_START, 8'h00);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (count_a !== 8'h00 || run_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_async count=%h running=%b required 00/0", count_a, run_a);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (count_a !== 8'h00 || run_a !== 1'b0 || tc_a !== 1'b0 || ready_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_release count=%h run=%b tc=%b ready=%b required 00/0/0/1",
                     count_a, run_a, tc_a, ready_a);
        end
        // Reset during the LOAD cycle must discard the pending load.
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 8'h56;
        step();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step(); step();
        checks++;
        if (count_a !== 8'h00 || ready_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_load count=%h ready=%b required 00/1", count_a, ready_a);
        end
        $display("test_reset done");
    endtask

    task automatic test_count();
        logic [7:0] exp;
        do_reset();
        issue(OP_START, 8'h00);
        checks++;
        if (run_a !== 1'b1 || count_a !== 8'h00) begin
            fails++;
            $display("FAIL start_enter running=%b count=%h required 1/00", run_a, count_a);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = 8'((k / 10) * 16 + (k % 10));
            checks++;
            if (count_a !== exp || run_a !== 1'b1 || tc_a !== 1'b0) begin
                fails++;
                $display("FAIL count_step k=%0d count=%h run=%b tc=%b required %h/1/0",
                         k, count_a, run_a, tc_a, exp);
            end
        end
        $display("test_count done count=%h", count_a);
    endtask

    task automatic test_terminal();
        do_reset();
        issue(OP_LOAD, 8'h98);
        step();
        checks++;
        if (count_a !== 8'h98 || count_b !== 8'h98) begin
            fails++;
            $display("FAIL term_load a=%h b=%h required 98", count_a, count_b);
        end
        issue(OP_START, 8'h00);
        step();
        checks++;
        if (count_a !== 8'h99 || tc_a !== 1'b0 || count_b !== 8'h99 || tc_b !== 1'b0) begin
            fails++;
            $display("FAIL term_99 a=%h tc_a=%b b=%h tc_b=%b required 99/0", count_a, tc_a, count_b, tc_b);
        end
        step();
        checks++;
        if (count_a !== 8'h00 || tc_a !== 1'b1 || run_a !== 1'b1) begin
            fails++;
            $display("FAIL wrap_edge count=%h tc=%b run=%b required 00/1/1", count_a, tc_a, run_a);
        end
        checks++;
        if (count_b !== 8'h99 || tc_b !== 1'b1 || run_b !== 1'b0) begin
            fails++;
            $display("FAIL sat_edge count=%h tc=%b run=%b required 99/1/0", count_b, tc_b, run_b);
        end
        step();
        checks++;
        if (count_a !== 8'h01 || tc_a !== 1'b0 || run_a !== 1'b1) begin
            fails++;
            $display("FAIL wrap_after count=%h tc=%b run=%b required 01/0/1", count_a, tc_a, run_a);
        end
        checks++;
        if (count_b !== 8'h99 || tc_b !== 1'b0 || run_b !== 1'b0) begin
            fails++;
            $display("FAIL sat_after count=%h tc=%b run=%b required 99/0/0", count_b, tc_b, run_b);
        end
        issue(OP_START, 8'h00);
        checks++;
        if (run_b !== 1'b1 || tc_b !== 1'b0) begin
            fails++;
            $display("FAIL sat_restart run=%b tc=%b required 1/0", run_b, tc_b);
        end
        step();
        checks++;
        if (count_b !== 8'h99 || tc_b !== 1'b1 || run_b !== 1'b0) begin
            fails++;
            $display("FAIL sat_refire count=%h tc=%b run=%b required 99/1/0", count_b, tc_b, run_b);
        end
        $display("test_terminal done");
    endtask

    task automatic test_load();
        do_reset();
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 8'hA7;
        step();
        checks++;
        if (ready_a !== 1'b0) begin
            fails++;
            $display("FAIL load_ready_low ready=%b required 0", ready_a);
        end
        // Hold a START (with different data) through the LOAD cycle.
        cmd_op = OP_START; cmd_data = 8'h33;
        step();
        checks++;
        if (count_a !== 8'h07 || ready_a !== 1'b1 || run_a !== 1'b0) begin
            fails++;
            $display("FAIL load_value count=%h ready=%b run=%b required 07/1/0", count_a, ready_a, run_a);
        end
        step();
        cmd_valid = 1'b0;
        checks++;
        if (run_a !== 1'b1 || count_a !== 8'h07) begin
            fails++;
            $display("FAIL load_held_cmd run=%b count=%h required 1/07", run_a, count_a);
        end
        issue(OP_STOP, 8'h00);
        issue(OP_LOAD, 8'h5B);
        step();
        checks++;
        if (count_a !== 8'h50) begin
            fails++;
            $display("FAIL load_low_digit count=%h required 50", count_a);
        end
        $display("test_load done");
    endtask

    task automatic test_prescale();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h00; exp_seq[1] = 8'h00; exp_seq[2] = 8'h01;
        do_reset();
        issue(OP_START, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (count_c !== exp_seq[k]) begin
                fails++;
                $display("FAIL presc_run k=%0d count=%h required %h", k, count_c, exp_seq[k]);
            end
        end
        step();
        issue(OP_STOP, 8'h00);
        checks++;
        if (run_c !== 1'b0 || count_c !== 8'h01) begin
            fails++;
            $display("FAIL presc_stop run=%b count=%h required 0/01", run_c, count_c);
        end
        issue(OP_START, 8'h00);
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h01; exp_seq[2] = 8'h02;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (count_c !== exp_seq[k]) begin
                fails++;
                $display("FAIL presc_restart k=%0d count=%h required %h", k, count_c, exp_seq[k]);
            end
        end
        $display("test_prescale done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(OP_LOAD, 8'h45);
        step();
        issue(OP_START, 8'h00);
        checks++;
        if (count_a !== 8'h45 || run_a !== 1'b1) begin
            fails++;
            $display("FAIL b2b_start count=%h run=%b required 45/1", count_a, run_a);
        end
        issue(OP_CLEAR, 8'h00);
        checks++;
        if (count_a !== 8'h00 || run_a !== 1'b1) begin
            fails++;
            $display("FAIL clear_on_tick count=%h run=%b required 00/1", count_a, run_a);
        end
        step();
        checks++;
        if (count_a !== 8'h01) begin
            fails++;
            $display("FAIL clear_resume count=%h required 01", count_a);
        end
        issue(OP_START, 8'h00);
        checks++;
        if (count_a !== 8'h02 || run_a !== 1'b1) begin
            fails++;
            $display("FAIL start_in_run count=%h run=%b required 02/1", count_a, run_a);
        end
        issue(OP_STOP, 8'h00);
        step();
        checks++;
        if (count_a !== 8'h02 || run_a !== 1'b0) begin
            fails++;
            $display("FAIL stop_on_tick count=%h run=%b required 02/0", count_a, run_a);
        end
        issue(OP_CLEAR, 8'h00);
        checks++;
        if (count_a !== 8'h00 || run_a !== 1'b0) begin
            fails++;
            $display("FAIL idle_clear count=%h run=%b required 00/0", count_a, run_a);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        test_reset();
        test_count();
        test_terminal();
        test_load();
        test_prescale();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
